// File: rtl/uart_alu_packet_engine.sv
// Command processor between uart_rx and uart_tx: parses opcode/rsv/len16 headers, then echoes the
// payload or folds it into add/sub operands and streams the little-endian result back out.
module uart_alu_packet_engine #(
    parameter int unsigned OPERAND_BYTES = 4,
    parameter logic [7:0]  OPC_ECHO      = 8'hEC,
    parameter logic [7:0]  OPC_ADD       = 8'h01,
    parameter logic [7:0]  OPC_SUB       = 8'h02
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] s_axis_tdata_i,
    input  logic       s_axis_tvalid_i,
    output logic       s_axis_tready_o,
    output logic [7:0] m_axis_tdata_o,
    output logic       m_axis_tvalid_o,
    input  logic       m_axis_tready_i,
    output logic       busy_o,
    output logic       err_o
);
    localparam int unsigned W        = 8 * OPERAND_BYTES;
    localparam logic [2:0]  IDX_LAST = 3'(OPERAND_BYTES - 1);
    localparam logic [3:0]  RES_END  = 4'(OPERAND_BYTES);

    typedef enum logic [2:0] {
        HDR_OPC, HDR_RSV, HDR_LEN_L, HDR_LEN_H, ECHO, ALU, DROP, RESULT
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     opc_q, opc_d;
    logic [7:0]     len_l_q, len_l_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   opnd_q, opnd_d;
    logic [2:0]     idx_q, idx_d;
    logic           first_q, first_d;
    logic [3:0]     res_idx_q, res_idx_d;
    logic           out_vld_q, out_vld_d;
    logic [7:0]     out_dat_q, out_dat_d;

    logic           s_hs, m_hs, slot_free, is_alu, last_byte;
    logic [15:0]    len_full, pay_cnt;
    logic [W-1:0]   opnd_full, acc_shift;

    assign is_alu    = (opc_q == OPC_ADD) || (opc_q == OPC_SUB);
    assign s_hs      = s_axis_tvalid_i && s_axis_tready_o;
    assign m_hs      = out_vld_q && m_axis_tready_i;
    assign slot_free = !out_vld_q || m_axis_tready_i;
    assign last_byte = (cnt_q == 16'd1);
    assign len_full  = {s_axis_tdata_i, len_l_q};
    // Length includes the 4 header bytes; shorter lengths mean an empty payload.
    assign pay_cnt   = (len_full < 16'd4) ? 16'd0 : len_full - 16'd4;
    assign opnd_full = opnd_q | (W'(s_axis_tdata_i) << {idx_q, 3'b000});
    assign acc_shift = acc_q >> {res_idx_q, 3'b000};

    assign m_axis_tdata_o  = out_dat_q;
    assign m_axis_tvalid_o = out_vld_q;
    assign busy_o          = (state_q != HDR_OPC);

    always_comb begin
        s_axis_tready_o = 1'b0;
        if (!reset_i) begin
            case (state_q)
                ECHO:    s_axis_tready_o = slot_free;
                RESULT:  s_axis_tready_o = 1'b0;
                default: s_axis_tready_o = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        len_l_d   = len_l_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        idx_d     = idx_q;
        first_d   = first_q;
        res_idx_d = res_idx_q;
        out_vld_d = m_hs ? 1'b0 : out_vld_q;
        out_dat_d = out_dat_q;
        err_o     = 1'b0;
        case (state_q)
            HDR_OPC: if (s_hs) begin
                opc_d   = s_axis_tdata_i;
                state_d = HDR_RSV;
            end
            HDR_RSV: if (s_hs) state_d = HDR_LEN_L;
            HDR_LEN_L: if (s_hs) begin
                len_l_d = s_axis_tdata_i;
                state_d = HDR_LEN_H;
            end
            HDR_LEN_H: if (s_hs) begin
                cnt_d     = pay_cnt;
                acc_d     = '0;
                opnd_d    = '0;
                idx_d     = '0;
                first_d   = 1'b1;
                res_idx_d = '0;
                if (opc_q == OPC_ECHO) begin
                    state_d = (pay_cnt == 16'd0) ? HDR_OPC : ECHO;
                end else if (is_alu) begin
                    state_d = (pay_cnt == 16'd0) ? RESULT : ALU;
                end else begin
                    err_o   = 1'b1;
                    state_d = (pay_cnt == 16'd0) ? HDR_OPC : DROP;
                end
            end
            ECHO: if (s_hs) begin
                out_dat_d = s_axis_tdata_i;
                out_vld_d = 1'b1;
                cnt_d     = cnt_q - 16'd1;
                if (last_byte) state_d = HDR_OPC;
            end
            ALU: if (s_hs) begin
                cnt_d = cnt_q - 16'd1;
                // A short trailing operand is committed zero-extended on the last byte.
                if (last_byte || idx_q == IDX_LAST) begin
                    first_d = 1'b0;
                    opnd_d  = '0;
                    idx_d   = '0;
                    if (first_q)                acc_d = opnd_full;
                    else if (opc_q == OPC_ADD)  acc_d = acc_q + opnd_full;
                    else                        acc_d = acc_q - opnd_full;
                end else begin
                    opnd_d = opnd_full;
                    idx_d  = idx_q + 3'd1;
                end
                if (last_byte) state_d = RESULT;
            end
            DROP: if (s_hs) begin
                cnt_d = cnt_q - 16'd1;
                if (last_byte) state_d = HDR_OPC;
            end
            RESULT: begin
                // An echo byte from the previous packet may still occupy the output slot.
                if (res_idx_q == RES_END) begin
                    if (m_hs) state_d = HDR_OPC;
                end else if (slot_free) begin
                    out_dat_d = acc_shift[7:0];
                    out_vld_d = 1'b1;
                    res_idx_d = res_idx_q + 4'd1;
                end
            end
            default: state_d = HDR_OPC;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= HDR_OPC;
            opc_q     <= '0;
            len_l_q   <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            idx_q     <= '0;
            first_q   <= 1'b1;
            res_idx_q <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            len_l_q   <= len_l_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            idx_q     <= idx_d;
            first_q   <= first_d;
            res_idx_q <= res_idx_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
        end
    end
endmodule
